// File: rtl/matmul_array_seq.sv
// matmul_array_seq
//   N x N unsigned matrix multiplier, R = W * X, accumulated as a sum of outer
//   products. Each operand beat k carries column k of W and row k of X.
//   Cell (i,j) then adds w_i*x_j to its accumulator. A small sequencer runs the
//   IDLE -> CLEAR -> ACCUM -> UNLOAD flow. Results stream out in row-major
//   order. With accumulate=1 the CLEAR step is skipped, so a new product
//   adds onto the retained results.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   start, accumulate       kick off a run (sampled in IDLE only)
//   busy                    high outside IDLE
//   in_valid/in_ready       operand beat handshake (ready only in ACCUM)
//   w_vec, x_vec            W column k / X row k, element e at [e*DW +: DW]
//   out_valid/out_ready     result handshake (valid throughout UNLOAD)
//   out_data, out_last      R[u/N][u%N]; last flags u == N*N-1
//   done                    pulse on the edge that accepts the last word

// One multiply-accumulate cell of the grid.
module matmul_mac #(
  parameter int DW   = 4,
  parameter int ACCW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [DW-1:0]   w_i,
  input  logic [DW-1:0]   x_i,
  output logic [ACCW-1:0] acc_o
);
  logic [ACCW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] prod;

  always_comb begin
    prod  = {{DW{1'b0}}, w_i} * {{DW{1'b0}}, x_i};
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACCW'(prod);  // wraps modulo 2^ACCW
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;

  assign acc_o = acc_q;
endmodule

module matmul_array_seq #(
  parameter int N    = 3,
  parameter int DW   = 4,
  parameter int ACCW = 2*DW + $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            accumulate,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] w_vec,
  input  logic [N*DW-1:0] x_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_data,
  output logic            out_last,
  output logic            done
);
  localparam int KW = $clog2(N);
  localparam int UW = $clog2(N*N);
  localparam logic [KW-1:0] K_LAST = KW'(N-1);
  localparam logic [UW-1:0] U_LAST = UW'(N*N-1);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, UNLOAD} state_e;

  state_e                      state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [UW-1:0]               u_q, u_d;
  logic                        clr, en;
  logic [N*N-1:0][ACCW-1:0]    acc;

  // Grid of cells, flattened row-major so the unload index addresses it directly.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      matmul_mac #(.DW(DW), .ACCW(ACCW)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (en),
        .w_i   (w_vec[i*DW +: DW]),
        .x_i   (x_vec[j*DW +: DW]),
        .acc_o (acc[i*N+j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      u_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      u_q     <= u_d;
    end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    u_d       = u_q;
    clr       = 1'b0;
    en        = 1'b0;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        k_d  = '0;
        u_d  = '0;
        if (start) state_d = accumulate ? ACCUM : CLEAR;
      end
      CLEAR: begin
        clr     = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          en = 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            u_d     = '0;
            state_d = UNLOAD;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_last  = (u_q == U_LAST);
        if (out_ready) begin
          if (out_last) begin
            done    = 1'b1;
            u_d     = '0;
            state_d = IDLE;
          end else begin
            u_d = u_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated so the data bus reads zero outside UNLOAD (including under reset).
  assign out_data = out_valid ? acc[u_q] : '0;
endmodule

// File: tb/tb_matmul_array_seq.sv
module tb_matmul_array_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: N=3, DW=4, ACCW=10
  logic        start3, acc3, busy3, in_valid3, in_ready3, out_valid3, out_ready3, out_last3, done3;
  logic [11:0] w_vec3, x_vec3;
  logic [9:0]  out_data3;
  // Instance B: N=4, DW=8, ACCW=18
  logic        start4, acc4, busy4, in_valid4, in_ready4, out_valid4, out_ready4, out_last4, done4;
  logic [31:0] w_vec4, x_vec4;
  logic [17:0] out_data4;

  matmul_array_seq #(.N(3), .DW(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .accumulate(acc3), .busy(busy3),
    .in_valid(in_valid3), .in_ready(in_ready3), .w_vec(w_vec3), .x_vec(x_vec3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .done(done3));

  matmul_array_seq #(.N(4), .DW(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .accumulate(acc4), .busy(busy4),
    .in_valid(in_valid4), .in_ready(in_ready4), .w_vec(w_vec4), .x_vec(x_vec4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_last(out_last4), .done(done4));

  typedef struct { longint data; bit last; } exp_t;
  exp_t q3[$], q4[$];

  int total = 0, bad = 0;
  int cnt3 = 0, cnt4 = 0;
  bit bp3 = 0, bp4 = 0;

  // Reference matrices: w[i][k] = W(i,k), x[k][j] = X(k,j), r = retained result.
  int w3[3][3], x3[3][3], r3[3][3];
  int w4[4][4], x4[4][4], r4[4][4];

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Sink-side ready, randomized when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    out_ready3 = bp3 ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready4 = bp4 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitors: compare the presented word against the queue head every cycle,
  // pop only on an accepted transfer (so held words are checked for stability).
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid3) begin
        if (q3.size() == 0) chk("unexpected_word3", 1, 0);
        else begin
          chk("data3", out_data3, q3[0].data);
          chk("last3", out_last3, q3[0].last);
          chk("done3", done3, q3[0].last && out_ready3);
          if (out_ready3) begin void'(q3.pop_front()); cnt3++; end
        end
      end else chk("done3_idle", done3, 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid4) begin
        if (q4.size() == 0) chk("unexpected_word4", 1, 0);
        else begin
          chk("data4", out_data4, q4[0].data);
          chk("last4", out_last4, q4[0].last);
          chk("done4", done4, q4[0].last && out_ready4);
          if (out_ready4) begin void'(q4.pop_front()); cnt4++; end
        end
      end else chk("done4_idle", done4, 0);
    end
  end

  task automatic zero_models();
    foreach (r3[i, j]) r3[i][j] = 0;
    foreach (r4[i, j]) r4[i][j] = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy3, 0);      chk("rst_in_ready", in_ready3, 0);
    chk("rst_out_valid", out_valid3, 0); chk("rst_out_last", out_last3, 0);
    chk("rst_done", done3, 0);      chk("rst_out_data", out_data3, 0);
  endtask

  task automatic set_identity3();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        w3[i][j] = (i == j) ? 1 : 0;
        x3[i][j] = i*3 + j + 1;
      end
  endtask

  task automatic set_const3(int v);
    foreach (w3[i, j]) begin w3[i][j] = v; x3[i][j] = v; end
  endtask

  // One full run on instance A. abort_after > 0 drops reset once that many
  // words have transferred.
  task automatic run3(bit accum, bit stall, int abort_after);
    exp_t e;
    int   n = 0, base;
    if (!accum) foreach (r3[i, j]) r3[i][j] = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int s = 0;
        for (int k = 0; k < 3; k++) s += w3[i][k] * x3[k][j];
        r3[i][j] = (r3[i][j] + s) % 1024;
        e.data = r3[i][j]; e.last = (i == 2 && j == 2);
        q3.push_back(e);
      end
    base = cnt3;
    start3 = 1; acc3 = accum;
    @(posedge clk); #1;
    start3 = 0; acc3 = 0;
    chk("accum_entry_first", in_ready3, accum);
    if (!accum) begin
      @(posedge clk); #1;
      chk("accum_entry_after_clear", in_ready3, 1);
    end
    for (int k = 0; k < 3; k++) begin
      if (stall && k > 0) begin
        in_valid3 = 0; start3 = 1;   // start during ACCUM must be ignored
        @(posedge clk); #1;
        start3 = 0;
        chk("stall_in_ready", in_ready3, 1);
      end
      in_valid3 = 1;
      for (int i = 0; i < 3; i++) begin
        w_vec3[i*4 +: 4] = 4'(w3[i][k]);
        x_vec3[i*4 +: 4] = 4'(x3[k][i]);
      end
      @(posedge clk); #1;
      in_valid3 = 0;
    end
    chk("first_out_valid", out_valid3, 1);
    while (q3.size() > 0 && n < 200) begin
      if (abort_after > 0 && cnt3 - base >= abort_after) break;
      @(posedge clk); #1; n++;
    end
    if (abort_after > 0) begin
      chk("abort_point_reached", cnt3 - base, abort_after);
      #2 rst_n = 0;
      #1;
      check_reset_outputs();
      q3.delete(); q4.delete();
      zero_models();
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
    end else begin
      chk("drain3", q3.size(), 0);
      chk("busy3_after_done", busy3, 0);
    end
  endtask

  task automatic run4(bit accum);
    exp_t e;
    int   n = 0;
    foreach (w4[i, j]) begin
      w4[i][j] = $urandom_range(0, 255);
      x4[i][j] = $urandom_range(0, 255);
    end
    if (!accum) foreach (r4[i, j]) r4[i][j] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 4; k++) s += w4[i][k] * x4[k][j];
        r4[i][j] = (r4[i][j] + s) % (1 << 18);
        e.data = r4[i][j]; e.last = (i == 3 && j == 3);
        q4.push_back(e);
      end
    start4 = 1; acc4 = accum;
    @(posedge clk); #1;
    start4 = 0; acc4 = 0;
    if (!accum) begin @(posedge clk); #1; end
    chk("accum4_ready", in_ready4, 1);
    for (int k = 0; k < 4; k++) begin
      in_valid4 = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid4 = 1;
      for (int i = 0; i < 4; i++) begin
        w_vec4[i*8 +: 8] = 8'(w4[i][k]);
        x_vec4[i*8 +: 8] = 8'(x4[k][i]);
      end
      @(posedge clk); #1;
      in_valid4 = 0;
    end
    while (q4.size() > 0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain4", q4.size(), 0);
    chk("busy4_after_done", busy4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    start3 = 0; acc3 = 0; in_valid3 = 0; w_vec3 = '0; x_vec3 = '0;
    start4 = 0; acc4 = 0; in_valid4 = 0; w_vec4 = '0; x_vec4 = '0;
    zero_models();
    #3;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    set_identity3();  run3(0, 0, 0);          // expect 1..9
    set_const3(15);   run3(0, 0, 0);          // expect 675 x9
    bp3 = 1;
    set_const3(15);   run3(0, 1, 0);          // stalls + backpressure, 675 x9
    bp3 = 0;
    set_const3(15);   run3(1, 0, 0);          // chained: 1350 mod 1024 = 326
    set_identity3();  run3(0, 0, 4);          // reset after 4 words
    set_identity3();  run3(0, 0, 0);          // clean run after abort
    bp3 = 1;
    foreach (w3[i, j]) begin w3[i][j] = $urandom_range(0, 15); x3[i][j] = $urandom_range(0, 15); end
    run3(0, 1, 0);
    foreach (w3[i, j]) begin w3[i][j] = $urandom_range(0, 15); x3[i][j] = $urandom_range(0, 15); end
    run3(1, 0, 0);
    bp3 = 0;

    run4(0);
    bp4 = 1;
    run4(0);
    run4(1);
    bp4 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
